// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_send transmitter between NUM_REQ byte producers. A pending
// request is arbitrated in IDLE, the winner's byte is latched onto tx_payload,
// tx_start is pulsed for one cycle, and no further grant is issued until a
// full UART frame plus a guard gap has elapsed. uart_send has no busy flag,
// so this block owns the frame timing.
//
// Build option:
//   UART_TX_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest set req wins
//                              undefined -> round-robin starting after last_grant
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   req          in   [NUM_REQ-1:0] level request per requester
//   req_data     in   [8*NUM_REQ-1:0] byte lanes, lane i = bits [8i+7:8i]
//   grant        out  [NUM_REQ-1:0] one-hot one-cycle pulse, lane's byte taken
//   tx_start     out  one-cycle start pulse to uart_send
//   tx_payload   out  [7:0] latched byte, stable from grant to next grant
//   busy         out  high from grant cycle through the end of the guard gap
//   dbg_state_o  out  [1:0] FSM state (0 IDLE, 1 LAUNCH, 2 WAIT)
//
// Handshake: a requester holds req high and its lane stable until it sees
// its grant bit. The byte is captured at the edge that raises grant. req
// still high after grant means another byte is pending; it is only looked at
// again once the FSM is back in IDLE. Dropping req before grant withdraws it.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int CLKS_PER_BIT = 104,
    parameter int FRAME_BITS   = 10,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   tx_start,
    output logic [7:0]             tx_payload,
    output logic                   busy,
    output logic [1:0]             dbg_state_o
);

    localparam int FRAME_WIN = CLKS_PER_BIT * FRAME_BITS + GUARD_CYCLES;
    localparam int CW        = $clog2(FRAME_WIN);
    localparam int IW        = $clog2(NUM_REQ);

    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_WIN - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        last_q, last_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           payload_q, payload_d;
    logic                 busy_q, busy_d;

    // Arbitration result, valid whenever win_found is high.
    logic                 win_found;
    logic [IW-1:0]        win_idx;
    logic [IW-1:0]        cand_idx;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [7:0]           win_data;

    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand_idx  = last_q;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        // Scan downward so the lowest set index is the last one written.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
`else
        // Search upward from last_grant+1, wrapping; last_grant itself is
        // checked last so a lone requester is still re-granted.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx = IW'((int'(last_q) + k) % NUM_REQ);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
`endif
        win_onehot = NUM_REQ'(1) << win_idx;
        win_data   = req_data[int'(win_idx) * 8 +: 8];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        grant_d    = '0;
        tx_start_d = 1'b0;
        payload_d  = payload_q;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (win_found) begin
                    grant_d   = win_onehot;
                    payload_d = win_data;
                    last_d    = win_idx;
                    busy_d    = 1'b1;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_start_d = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // Counter is 0 in the tx_start cycle; the window closes after
                // FRAME_WIN cycles counted from there.
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= LAST_RST;
            grant_q    <= '0;
            tx_start_q <= 1'b0;
            payload_q  <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            tx_start_q <= tx_start_d;
            payload_q  <= payload_d;
            busy_q     <= busy_d;
        end
    end

    assign grant       = grant_q;
    assign tx_start    = tx_start_q;
    assign tx_payload  = payload_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 2;
  localparam int CPB = 4;
  localparam int FB = 10;
  localparam int GUARD = 2;
  localparam int WIN = CPB * FB + GUARD;   // 42
  localparam int GAP = WIN + 2;            // 44

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_REQ-1:0] req = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0] grant;
  logic tx_start;
  logic [7:0] tx_payload;
  logic busy;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .CLKS_PER_BIT(CPB),
    .FRAME_BITS(FB),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .grant(grant),
    .tx_start(tx_start),
    .tx_payload(tx_payload),
    .busy(busy),
    .dbg_state_o(dbg_state)
  );

  // scoreboard: {grant, payload}
  logic [9:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int last_start = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait up to budget cycles for a grant, compare it against the scoreboard,
  // then check the tx_start pulse one cycle later. exp_gap>0 also checks the
  // distance to the previous tx_start.
  task automatic take_grant(input string tag, input int budget, input int exp_gap);
    logic [9:0] exp_v;
    int n;
    n = 1;
    tick();
    while (grant === '0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) exp_v = exp_q.pop_front();
    else exp_v = 'x;
    check({tag, "_grant"}, {22'd0, grant, tx_payload}, {22'd0, exp_v});
    check({tag, "_grant_nostart"}, {31'd0, tx_start}, 32'd0);
    tick();
    check({tag, "_start"}, {29'd0, tx_start, grant}, {29'd0, 3'b100});
    if (exp_gap > 0) check({tag, "_gap"}, cyc - last_start, exp_gap);
    last_start = cyc;
  endtask

  // Called in the tx_start cycle; runs the WAIT window out to IDLE.
  task automatic finish_frame(input string tag);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < WIN - 1; i++) begin
      tick();
      bad = bad | tx_start | (|grant) | ~busy;
    end
    check({tag, "_wait_quiet"}, {31'd0, bad}, 32'd0);
    check({tag, "_busy_last"}, {31'd0, busy}, 32'd1);
    tick();
    check({tag, "_busy_low"}, {30'd0, busy, dbg_state == 2'd0}, {30'd0, 2'b01});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, idle
    tick();
    do_reset();
    repeat (10) tick();
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_txstart_busy", {30'd0, tx_start, busy}, 32'd0);
    check("rst_payload", {24'd0, tx_payload}, 32'h00);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    // 2: single request, latency and window length
    req = 2'b01;
    req_data = {8'h00, 8'h41};
    exp_q.push_back({2'b01, 8'h41});
    take_grant("single", 1, 0);
    req = '0;
    check("single_payload_hold", {24'd0, tx_payload}, 32'h41);
    finish_frame("single");

    // withdraw before grant
    req = 2'b01;
    #2;
    req = '0;
    repeat (5) tick();
    check("withdraw", {29'd0, grant, busy}, 32'd0);

    // 3: both requesting, rotation and spacing
    do_reset();
    req = 2'b11;
    req_data = {8'hB1, 8'hA0};
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    exp_q.push_back({2'b01, 8'hA0});
    exp_q.push_back({2'b01, 8'hA0});
    exp_q.push_back({2'b01, 8'hA0});
`else
    exp_q.push_back({2'b01, 8'hA0});
    exp_q.push_back({2'b10, 8'hB1});
    exp_q.push_back({2'b01, 8'hA0});
`endif
    take_grant("rr0", 2, 0);
    take_grant("rr1", 60, GAP);
    take_grant("rr2", 60, GAP);
    req = '0;
    finish_frame("rr");

    // 4: late request during WAIT waits for IDLE
    req = 2'b01;
    req_data = {8'h00, 8'h11};
    exp_q.push_back({2'b01, 8'h11});
    take_grant("late0", 2, 0);
    req = '0;
    repeat (5) tick();
    req = 2'b10;
    req_data = {8'h7E, 8'h00};
    exp_q.push_back({2'b10, 8'h7E});
    take_grant("late1", 60, GAP);
    req = '0;
    finish_frame("late");

    // 5: reset mid-WAIT
    req = 2'b01;
    req_data = {8'h00, 8'h55};
    exp_q.push_back({2'b01, 8'h55});
    take_grant("rstw", 2, 0);
    req = '0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("rstw_ctrl", {29'd0, grant, tx_start, busy}, 32'd0);
    check("rstw_payload", {24'd0, tx_payload}, 32'h00);
    check("rstw_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    req = 2'b11;
    req_data = {8'hB1, 8'hA0};
    exp_q.push_back({2'b01, 8'hA0});
    take_grant("rstw_after", 2, 0);
    req = '0;
    finish_frame("rstw_after");

    // reset mid-LAUNCH: no tx_start
    req = 2'b01;
    req_data = {8'h00, 8'h66};
    tick();
    check("rstl_grant", {22'd0, grant, tx_payload}, {22'd0, 2'b01, 8'h66});
    rst = 1'b1;
    req = '0;
    tick();
    check("rstl_ctrl", {29'd0, grant, tx_start, busy}, 32'd0);
    check("rstl_payload", {24'd0, tx_payload}, 32'h00);
    rst = 1'b0;
    tick();
    check("rstl_nostart", {31'd0, tx_start}, 32'd0);

    // 6: single persistent requester re-granted every frame
    req = 2'b10;
    req_data = {8'hC3, 8'h00};
    exp_q.push_back({2'b10, 8'hC3});
    exp_q.push_back({2'b10, 8'hC3});
    take_grant("pers0", 2, 0);
    take_grant("pers1", 60, GAP);
    req = '0;
    finish_frame("pers");

    check("sb_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart_send transmitter between NUM_REQ byte producers, e.g. the RX echo path and the CPU output port.
- Arbitrates pending requests and latches the winner's byte.
- Pulses the transmitter's start input for one cycle, then holds off new grants until a full frame plus a guard gap has elapsed.
- uart_send exposes no busy flag, so this block owns frame timing.
- Sits between the producers and uart_send in top.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- CLKS_PER_BIT, 104, clock cycles per UART bit. Must match uart_send (12 MHz / 115200).
- FRAME_BITS, 10, bits per frame: start + 8 data + stop.
- GUARD_CYCLES, 2, extra idle cycles after each frame before the next grant.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  level request per requester; high = byte pending on its req_data lane.
- req_data  input  8*NUM_REQ  byte lanes; lane i = bits [8i+7:8i].
- grant  output  NUM_REQ  one-hot, one-cycle pulse: lane's byte has been taken.
- tx_start  output  1  one-cycle pulse; drives uart_send ready.
- tx_payload  output  8  latched byte; drives uart_send payload; stable from grant until the next grant.
- busy  output  1  high from grant cycle through end of the guard gap.

Behaviour:
- Reset (rst=1 sampled at an edge):
  - grant=0, tx_start=0, tx_payload=8'h00, busy=0.
  - state=IDLE, counter=0, last_grant=NUM_REQ-1, so req[0] wins first.
- States: IDLE, LAUNCH, WAIT.
- IDLE:
  - If req is nonzero at edge n, pick the winner round-robin: the first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - At that same edge: grant[winner]=1, tx_payload=lane[winner], last_grant=winner, busy=1, go to LAUNCH.
  - If req is zero, stay in IDLE with outputs low.
- LAUNCH (one cycle): grant=0, tx_start=1, counter=0, go to WAIT.
- WAIT:
  - tx_start=0; counter increments each cycle.
  - When counter reaches CLKS_PER_BIT*FRAME_BITS+GUARD_CYCLES-1: busy=0, go to IDLE.
  - Counter width = clog2(CLKS_PER_BIT*FRAME_BITS+GUARD_CYCLES).
- Latency:
  - req sampled at edge n → grant high in cycle n+1 → tx_start high in cycle n+2.
  - Minimum spacing between consecutive tx_start pulses = CLKS_PER_BIT*FRAME_BITS+GUARD_CYCLES+2 cycles.
- Handshake:
  - Requester holds req and data stable until it sees grant.
  - If req is still high in the cycle after grant, it means another byte is pending. The requester must update data by then; re-arbitration only happens after WAIT.
  - Dropping req before grant withdraws the request without side effect.
- Boundaries:
  - Simultaneous requests: exactly one grant per arbitration, never more than one grant bit high.
  - Requests arriving during LAUNCH/WAIT are ignored until IDLE.
  - A single persistent requester with no competitors is re-granted every frame.
  - Non-winning requesters are not starved: with all req high, grants rotate 0,1,...,NUM_REQ-1,0.
  - Reset mid-WAIT or mid-LAUNCH: immediate return to reset values, no tx_start issued. uart_send shares rst, so the partial frame aborts.
- No combinational path from req/req_data to any output; all outputs are registered.

Optional Feature:
- Macro: UART_TX_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Lowest-index set req bit wins; last_grant is still tracked but unused for selection.
- Undefined: round-robin as above.
- Timing, handshake and reset behaviour are identical in both builds.

Test Plan (CLKS_PER_BIT=4, FRAME_BITS=10, GUARD_CYCLES=2; frame window = 42 cycles):
- Reset then idle 10 cycles, req=0 → grant, tx_start, busy all 0; tx_payload=8'h00.
- req=2'b01, lane0=8'h41 at edge n → grant=2'b01 in cycle n+1, tx_payload=8'h41, tx_start high only in cycle n+2, busy low 42 cycles after LAUNCH.
- req=2'b11 held, lane0=8'hA0, lane1=8'hB1 → grants alternate 01,10,01; tx_payload sequence A0,B1,A0; tx_start pulses exactly 44 cycles apart.
- req[1] asserted in WAIT of a req[0] byte, lane1=8'h7E → no grant until IDLE, then grant=2'b10, tx_payload=8'h7E.
- rst pulsed 5 cycles into WAIT → next cycle busy=0, grant=0, tx_payload=8'h00. With req=2'b11 afterwards, grant=2'b01 first.
- UART_TX_ARB_FIXED_PRIO_EN defined, req=2'b11 held → grant=2'b01 every frame, lane1 never granted.
